// File: rtl/counter_updn_mod.sv
// counter_updn_mod: parametrised up/down counter with wrap or saturate, load, terminal count and sticky overflow
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   en       count enable
//   updn     direction, 1 = up, 0 = down
//   load     synchronous parallel load, beats en
//   din      load value, clamped to MAX_VAL
//   clr_ovf  synchronous clear of ovf; a same-edge set wins
//   q        registered count in 0..MAX_VAL
//   tc       combinational terminal count (next enabled step crosses a boundary)
//   ovf      sticky registered boundary-crossing flag
module counter_updn_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 15,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic             SAT  = (SATURATE != 0);
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] q_next;
  assign at_top = (q == MAXV);
  assign at_bot = (q == '0);
  assign tc     = en & ~load & (updn ? at_top : at_bot);
  // at a boundary saturation holds q, otherwise the count wraps to the opposite end
  assign up_val = at_top ? (SAT ? q : '0)   : q + 1'b1;
  assign dn_val = at_bot ? (SAT ? q : MAXV) : q - 1'b1;
  always_comb begin
    q_next = load ? ((din > MAXV) ? MAXV : din) : !en ? q : updn ? up_val : dn_val;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= tc | (ovf & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_counter_updn_mod.sv
// tb_counter_updn_mod: three counter configurations driven in lockstep and checked against an arithmetic model
module tb_counter_updn_mod;
  logic       clk;
  logic       rst;
  logic       en;
  logic       updn;
  logic       load;
  logic [3:0] din;
  logic       clr_ovf;
  logic [3:0] dq[3];
  logic       dtc[3];
  logic       dovf[3];
  int         tests = 0;
  int         fails = 0;
  int         mx[3] = '{15, 9, 15};
  bit         st[3] = '{1'b0, 1'b0, 1'b1};
  int         mq[3];
  bit         movf[3];

  counter_updn_mod #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) d0 (
    .clk(clk), .rst(rst), .en(en), .updn(updn), .load(load), .din(din),
    .clr_ovf(clr_ovf), .q(dq[0]), .tc(dtc[0]), .ovf(dovf[0]));
  counter_updn_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) d9 (
    .clk(clk), .rst(rst), .en(en), .updn(updn), .load(load), .din(din),
    .clr_ovf(clr_ovf), .q(dq[1]), .tc(dtc[1]), .ovf(dovf[1]));
  counter_updn_mod #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1)) ds (
    .clk(clk), .rst(rst), .en(en), .updn(updn), .load(load), .din(din),
    .clr_ovf(clr_ovf), .q(dq[2]), .tc(dtc[2]), .ovf(dovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit mtc(int i);
    return en && !load && (updn ? (mq[i] == mx[i]) : (mq[i] == 0));
  endfunction

  // modular arithmetic for wrap, clamping for saturate
  function automatic int mnext(int i);
    if (load) return (int'(din) > mx[i]) ? mx[i] : int'(din);
    if (!en) return mq[i];
    if (st[i]) return updn ? ((mq[i] + 1 > mx[i]) ? mx[i] : mq[i] + 1)
                           : ((mq[i] - 1 < 0) ? 0 : mq[i] - 1);
    return updn ? (mq[i] + 1) % (mx[i] + 1) : (mq[i] + mx[i]) % (mx[i] + 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mq[i]   <= 0;
        movf[i] <= 1'b0;
      end else begin
        mq[i]   <= mnext(i);
        movf[i] <= mtc(i) | (movf[i] & ~clr_ovf);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_q[%0d]", i), dq[i], mq[i]);
      chk($sformatf("model_tc[%0d]", i), dtc[i], mtc(i));
      chk($sformatf("model_ovf[%0d]", i), dovf[i], movf[i]);
    end
  end

  task automatic cyc(input bit e, input bit u, input bit l, input int d, input bit c);
    en = e; updn = u; load = l; din = 4'(d); clr_ovf = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; updn = 1'b0; load = 1'b0; din = '0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_q", dq[0], 0);
    chk("reset_ovf", dovf[0], 0);
    rst = 1'b1;
    repeat (15) cyc(1, 1, 0, 0, 0);
    chk("up_q15", dq[0], 15);
    chk("up_tc_at15", dtc[0], 1);
    chk("up_ovf_before_wrap", dovf[0], 0);
    chk("sat_q15", dq[2], 15);
    cyc(1, 1, 0, 0, 0);
    chk("up_wrap_q0", dq[0], 0);
    chk("up_wrap_ovf", dovf[0], 1);
    chk("up_tc_after_wrap", dtc[0], 0);
    cyc(1, 1, 0, 0, 0);
    chk("up_q1", dq[0], 1);
    cyc(1, 1, 0, 0, 0);
    chk("sat_hold_q", dq[2], 15);
    chk("sat_hold_tc", dtc[2], 1);
    chk("sat_ovf", dovf[2], 1);
    cyc(1, 0, 0, 0, 0);
    chk("sat_down_q14", dq[2], 14);
    chk("down_d0_q1", dq[0], 1);
    repeat (6) cyc(1, 1, 0, 0, 0);
    chk("midcount_q7", dq[0], 7);
    rst = 1'b0;
    #1;
    chk("async_reset_q", dq[0], 0);
    chk("async_reset_ovf", dovf[0], 0);
    chk("async_reset_sat_ovf", dovf[2], 0);
    cyc(1, 1, 0, 0, 0);
    chk("reset_held_q", dq[0], 0);
    rst = 1'b1;
    cyc(1, 1, 0, 0, 0);
    chk("first_edge_after_reset", dq[0], 1);
    cyc(1, 1, 1, 0, 0);
    chk("load_zero", dq[1], 0);
    cyc(1, 0, 0, 0, 0);
    chk("down_wrap_q9", dq[1], 9);
    chk("down_wrap_ovf", dovf[1], 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", dovf[1], 0);
    chk("clr_hold_q", dq[1], 9);
    cyc(1, 1, 0, 0, 1);
    chk("set_beats_clr_ovf", dovf[1], 1);
    chk("set_beats_clr_q", dq[1], 0);
    cyc(1, 1, 1, 5, 0);
    chk("load_beats_count", dq[0], 5);
    cyc(1, 1, 1, 12, 0);
    chk("load_clamp_9", dq[1], 9);
    chk("load_unclamped_12", dq[0], 12);
    cyc(0, 1, 1, 4, 0);
    for (int k = 0; k < 5; k++) cyc(0, k[0], 0, 0, 0);
    chk("enable_hold", dq[0], 4);
    cyc(1, 1, 0, 0, 0);
    chk("toggle_5a", dq[0], 5);
    cyc(1, 0, 0, 0, 0);
    chk("toggle_4a", dq[0], 4);
    cyc(1, 1, 0, 0, 0);
    chk("toggle_5b", dq[0], 5);
    cyc(1, 0, 0, 0, 0);
    chk("toggle_4b", dq[0], 4);
    cyc(0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
